inst_fetch_unit: RTL and testbench

- Instruction-fetch front end sitting directly upstream of the AXI bridge's instruction sram_like port.
- Holds the fetch PC, issues one instruction read at a time, and buffers returned words with their PCs in a small FIFO.
- Presents the buffered words to decode through a valid/ready handshake.
- Handles redirects (branch, exception, ERET) by flushing the FIFO and discarding any in-flight response.

---
 rtl/fetch_pkg.sv | 34 +++
 rtl/fetch_fifo.sv | 76 +++++++
 rtl/inst_fetch_unit.sv | 146 ++++++++++++++
 tb/tb_inst_fetch_unit.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg
// Shared constants and types for the instruction-fetch front end.
//   ADDR_W / INST_W   : bus address and instruction word widths
//   FETCH_RESET_PC    : default fetch address after reset (boot ROM vector)
//   fetch_entry_t     : one buffered fetch result {adel, pc, inst}
//   FETCH_ENTRY_W     : packed width of fetch_entry_t
package fetch_pkg;

  localparam int ADDR_W        = 32;
  localparam int INST_W        = 32;
  localparam int FETCH_ENTRY_W = 1 + ADDR_W + INST_W;

  localparam logic [ADDR_W-1:0] FETCH_RESET_PC = 32'hBFC0_0000;

  // Layout matches {adel, pc[31:0], inst[31:0]}, so the struct can be
  // stored in the FIFO as a flat FETCH_ENTRY_W-bit vector.
  typedef struct packed {
    logic              adel;
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  // Builds a FIFO entry from its three fields.
  function automatic fetch_entry_t packEntry(input logic adel,
                                             input logic [ADDR_W-1:0] pc,
                                             input logic [INST_W-1:0] inst);
    fetch_entry_t e;
    e.adel = adel;
    e.pc   = pc;
    e.inst = inst;
    return e;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo
// Small synchronous FIFO that buffers fetched instructions for decode.
// Ports:
//   clk, rst_p     : clock and synchronous active-high reset
//   push/push_data : write one entry at the tail
//   pop            : remove the head entry
//   flush          : empty the FIFO; wins over a same-cycle push or pop
//   head_data      : current head entry (valid when !empty)
//   count          : number of stored entries (0..DEPTH)
//   empty, full    : occupancy flags
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 65
) (
  input  logic                     clk,
  input  logic                     rst_p,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_rdPtr;
  logic [PTR_W-1:0] r_wrPtr;
  logic [CNT_W-1:0] r_count;
  logic             w_doPush;
  logic             w_doPop;

  // Requests that cannot be honoured (pop when empty, push when full with
  // no simultaneous pop) are ignored so the pointers can never slip.
  assign w_doPop  = pop && !empty;
  assign w_doPush = push && (!full || w_doPop);

  assign empty     = (r_count == '0);
  assign full      = (r_count == CNT_W'(DEPTH));
  assign count     = r_count;
  assign head_data = r_mem[r_rdPtr];

  // Storage array; no reset needed because the count gates visibility.
  always_ff @(posedge clk) begin
    if (w_doPush && !flush) begin
      r_mem[r_wrPtr] <= push_data;
    end
  end

  // Pointers and occupancy. DEPTH is a power of two so the pointers wrap
  // naturally; flush resets everything and voids any same-cycle push/pop.
  always_ff @(posedge clk) begin
    if (rst_p || flush) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) begin
        r_wrPtr <= r_wrPtr + PTR_W'(1);
      end
      if (w_doPop) begin
        r_rdPtr <= r_rdPtr + PTR_W'(1);
      end
      if (w_doPush && !w_doPop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (w_doPop && !w_doPush) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit
// Instruction-fetch front end in front of the bridge's sram_like port.
// Keeps the fetch PC, issues one read at a time, buffers returned words with
// their PCs, and hands them to decode over a valid/ready handshake.
// Ports:
//   clk, rst_p                    : clock, synchronous active-high reset
//   redirect_valid, redirect_pc   : flush and restart fetch at redirect_pc
//   out_valid/out_ready           : decode handshake for the FIFO head
//   out_inst, out_pc, out_adel    : head word, its PC, address-error flag
//   inst_req, inst_addr           : sram_like request and address
//   inst_addr_ok, inst_data_ok    : bridge address / data handshakes
//   inst_rdata                    : returned instruction word
module inst_fetch_unit
  import fetch_pkg::*;
#(
  parameter int                FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC   = FETCH_RESET_PC
) (
  input  logic              clk,
  input  logic              rst_p,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] out_inst,
  output logic [ADDR_W-1:0] out_pc,
  output logic              out_adel,
  output logic              inst_req,
  output logic [ADDR_W-1:0] inst_addr,
  input  logic              inst_addr_ok,
  input  logic              inst_data_ok,
  input  logic [INST_W-1:0] inst_rdata
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [ADDR_W-1:0]        r_fetchPc;
  logic [ADDR_W-1:0]        r_pendingPc;
  logic                     r_pending;
  logic                     r_discard;
  logic                     r_halted;

  logic                     w_full;
  logic                     w_empty;
  logic [CNT_W-1:0]         w_count;
  logic                     w_addrHs;
  logic                     w_resp;
  logic                     w_misalign;
  logic                     w_push;
  logic                     w_pop;
  fetch_entry_t             w_pushEntry;
  fetch_entry_t             w_headEntry;
  logic [FETCH_ENTRY_W-1:0] w_headRaw;

  // A request is only issued when a FIFO slot is guaranteed for its
  // response: nothing outstanding and at least one free entry. Held reset
  // and redirects also suppress the request so no address handshake can
  // race with them.
  assign inst_req  = !rst_p && !r_pending && !r_halted && !redirect_valid &&
                     !w_full && (r_fetchPc[1:0] == 2'b00);
  assign inst_addr = r_fetchPc;
  assign w_addrHs  = inst_req && inst_addr_ok;
  assign w_resp    = inst_data_ok && r_pending;

  // A misaligned PC is reported as a single address-error entry instead of
  // a bus read; it uses the same slot-reservation conditions as a request.
  assign w_misalign = !redirect_valid && !r_halted && !r_pending && !w_full &&
                      (r_fetchPc[1:0] != 2'b00);

  // Responses and misaligned markers are mutually exclusive (one needs
  // pending, the other needs it clear), so a simple mux selects the entry.
  assign w_push = !redirect_valid && ((w_resp && !r_discard) || w_misalign);
  assign w_pushEntry = w_misalign ? packEntry(1'b1, r_fetchPc, '0)
                                  : packEntry(1'b0, r_pendingPc, inst_rdata);
  assign w_pop = out_valid && out_ready;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FETCH_ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .rst_p     (rst_p),
    .push      (w_push),
    .push_data (w_pushEntry),
    .pop       (w_pop),
    .flush     (redirect_valid),
    .head_data (w_headRaw),
    .count     (w_count),
    .empty     (w_empty),
    .full      (w_full)
  );

  assign w_headEntry = fetch_entry_t'(w_headRaw);
  assign out_valid   = !w_empty;
  assign out_inst    = w_headEntry.inst;
  assign out_pc      = w_headEntry.pc;
  assign out_adel    = w_headEntry.adel;

  // Fetch control. A redirect overrides everything in its cycle: the PC is
  // replaced and halt cleared; an outstanding read either returns now (and
  // is dropped) or is marked for discard when it eventually returns. The
  // discard mark survives further redirects since only one read is ever
  // outstanding.
  always_ff @(posedge clk) begin
    if (rst_p) begin
      r_fetchPc   <= RESET_PC;
      r_pendingPc <= '0;
      r_pending   <= 1'b0;
      r_discard   <= 1'b0;
      r_halted    <= 1'b0;
    end else if (redirect_valid) begin
      r_fetchPc <= redirect_pc;
      r_halted  <= 1'b0;
      if (w_resp) begin
        r_pending <= 1'b0;
        r_discard <= 1'b0;
      end else if (r_pending) begin
        r_discard <= 1'b1;
      end
    end else begin
      if (w_addrHs) begin
        r_pending   <= 1'b1;
        r_pendingPc <= r_fetchPc;
        r_fetchPc   <= r_fetchPc + 32'd4;
      end
      if (w_resp) begin
        r_pending <= 1'b0;
        r_discard <= 1'b0;
      end
      if (w_misalign) begin
        r_halted <= 1'b1;
      end
    end
  end

  // Protocol and invariant checks.
  assert property (@(posedge clk) disable iff (rst_p)
                   w_count <= CNT_W'(FIFO_DEPTH));
  assert property (@(posedge clk) disable iff (rst_p)
                   inst_req |-> !r_pending);
  assert property (@(posedge clk) disable iff (rst_p)
                   w_push |-> !r_discard);
  assert property (@(posedge clk) disable iff (rst_p)
                   inst_data_ok |-> r_pending);

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit
// Directed bench for inst_fetch_unit with an in-bench bridge model and a
// scoreboard of expected FIFO entries {adel, pc, inst}.
module tb_inst_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_p = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        out_adel;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok = 1'b0;
  logic        inst_data_ok = 1'b0;
  logic [31:0] inst_rdata = 32'h0;

  int          vecCount = 0;
  int          missCount = 0;
  int          popCount = 0;
  logic [31:0] lastPopPc = 32'h0;
  logic [64:0] sbq[$];
  logic [31:0] addrLog[$];

  logic        bPend = 1'b0;
  logic        bDiscard = 1'b0;
  logic [31:0] bAddr = 32'h0;
  int          bDelay = 0;
  int          lat = 1;

  inst_fetch_unit #(
    .FIFO_DEPTH (4),
    .RESET_PC   (32'hBFC0_0000)
  ) dut (
    .clk            (clk),
    .rst_p          (rst_p),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc),
    .out_adel       (out_adel),
    .inst_req       (inst_req),
    .inst_addr      (inst_addr),
    .inst_addr_ok   (inst_addr_ok),
    .inst_data_ok   (inst_data_ok),
    .inst_rdata     (inst_rdata)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Contents of the modelled instruction memory at a given address.
  function automatic logic [31:0] memWord(input logic [31:0] addr);
    return {addr[15:0] ^ 16'h5A3C, addr[31:16] ^ 16'h0F0F};
  endfunction

  // One comparison: counts it, and reports tag/observed/expected on a miss.
  task automatic checkOutput(input string tag, input logic [64:0] got,
                             input logic [64:0] exp);
    vecCount++;
    assert (got === exp) else begin
      missCount++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One clock cycle, entered and left at the falling edge. Drives the bridge
  // response, accepts any request immediately, keeps the scoreboard in step
  // with flushes/pushes, and compares every popped head against it.
  task automatic applyStimulus();
    logic        hs;
    logic [31:0] hsAddr;
    logic [64:0] exp;
    if (rst_p) begin
      bPend    = 1'b0;
      bDiscard = 1'b0;
      sbq.delete();
    end
    inst_data_ok = bPend && (bDelay == 0);
    inst_rdata   = inst_data_ok ? memWord(bAddr) : 32'h0;
    if (redirect_valid && !rst_p) begin
      sbq.delete();
      if (bPend && !inst_data_ok) bDiscard = 1'b1;
      if (redirect_pc[1:0] != 2'b00) sbq.push_back({1'b1, redirect_pc, 32'h0});
    end else if (inst_data_ok && !bDiscard && !rst_p) begin
      sbq.push_back({1'b0, bAddr, memWord(bAddr)});
    end
    #1;
    hs           = inst_req;
    hsAddr       = inst_addr;
    inst_addr_ok = inst_req;
    if (hs) addrLog.push_back(hsAddr);
    #1;
    if (out_valid && out_ready && !redirect_valid && !rst_p) begin
      if (sbq.size() == 0) begin
        checkOutput("pop_unexpected", 65'(out_valid), 65'd0);
      end else begin
        exp = sbq.pop_front();
        checkOutput("head_entry", {out_adel, out_pc, out_inst}, exp);
      end
      popCount++;
      lastPopPc = out_pc;
    end
    @(posedge clk);
    if (inst_data_ok) begin
      bPend    = 1'b0;
      bDiscard = 1'b0;
    end else if (bPend) begin
      bDelay--;
    end
    if (hs) begin
      bPend  = 1'b1;
      bAddr  = hsAddr;
      bDelay = lat - 1;
    end
    @(negedge clk);
  endtask

  // Holds reset for two edges; outputs must be idle while it is held.
  task automatic applyReset();
    rst_p          = 1'b1;
    redirect_valid = 1'b0;
    applyStimulus();
    #1;
    checkOutput("rst_out_valid", 65'(out_valid), 65'd0);
    checkOutput("rst_inst_req", 65'(inst_req), 65'd0);
    applyStimulus();
    rst_p = 1'b0;
    addrLog.delete();
    popCount = 0;
  endtask

  // Bounded wait until n address handshakes have been logged.
  task automatic waitAddrs(input int n, input int limit, input string tag);
    for (int i = 0; i < limit && addrLog.size() < n; i++) applyStimulus();
    checkOutput(tag, 65'(addrLog.size() >= n), 65'd1);
  endtask

  // Bounded wait until n heads have been popped since the last reset.
  task automatic waitPops(input int n, input int limit, input string tag);
    for (int i = 0; i < limit && popCount < n; i++) applyStimulus();
    checkOutput(tag, 65'(popCount >= n), 65'd1);
  endtask

  // Directed sequence covering streaming, back-pressure, redirects,
  // misaligned fetch and reset in the middle of a transaction.
  initial begin
    @(negedge clk);

    $display("[TB] streaming fetch");
    lat = 1;
    out_ready = 1'b1;
    applyReset();
    #1;
    checkOutput("post_rst_addr", 65'(inst_addr), 65'h0BFC0_0000);
    waitAddrs(3, 20, "stream_wait");
    checkOutput("stream_addr0", 65'(addrLog[0]), 65'h0BFC0_0000);
    checkOutput("stream_addr1", 65'(addrLog[1]), 65'h0BFC0_0004);
    checkOutput("stream_addr2", 65'(addrLog[2]), 65'h0BFC0_0008);
    waitPops(3, 20, "stream_pops");

    $display("[TB] decode stall fills FIFO");
    out_ready = 1'b0;
    applyReset();
    for (int i = 0; i < 14; i++) applyStimulus();
    checkOutput("full_handshakes", 65'(addrLog.size()), 65'd4);
    checkOutput("full_inst_req", 65'(inst_req), 65'd0);
    checkOutput("full_out_valid", 65'(out_valid), 65'd1);
    checkOutput("full_head_pc", 65'(out_pc), 65'h0BFC0_0000);
    out_ready = 1'b1;
    waitAddrs(5, 12, "resume_wait");
    checkOutput("resume_addr", 65'(addrLog[4]), 65'h0BFC0_0010);
    waitPops(5, 20, "resume_pops");

    $display("[TB] redirect with a pending read");
    lat = 3;
    applyReset();
    waitAddrs(3, 30, "pend_wait");
    checkOutput("pend_addr", 65'(addrLog[2]), 65'h0BFC0_0008);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0100;
    applyStimulus();
    redirect_valid = 1'b0;
    #1;
    checkOutput("redir_empty", 65'(out_valid), 65'd0);
    checkOutput("redir_no_req", 65'(inst_req), 65'd0);
    waitAddrs(4, 15, "redir_wait");
    checkOutput("redir_addr", 65'(addrLog[3]), 65'h0_8000_0100);
    popCount = 0;
    waitPops(1, 15, "redir_pop");
    checkOutput("redir_first_pc", 65'(lastPopPc), 65'h0_8000_0100);

    $display("[TB] redirect coincident with data");
    lat = 1;
    applyReset();
    waitAddrs(1, 5, "coinc_wait");
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0300;
    applyStimulus();
    redirect_valid = 1'b0;
    #1;
    checkOutput("coinc_req", 65'(inst_req), 65'd1);
    checkOutput("coinc_addr", 65'(inst_addr), 65'h0_8000_0300);
    checkOutput("coinc_empty", 65'(out_valid), 65'd0);
    waitPops(1, 10, "coinc_pop");
    checkOutput("coinc_first_pc", 65'(lastPopPc), 65'h0_8000_0300);

    $display("[TB] misaligned redirect");
    out_ready = 1'b0;
    applyReset();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0102;
    applyStimulus();
    redirect_valid = 1'b0;
    #1;
    checkOutput("adel_no_req", 65'(inst_req), 65'd0);
    applyStimulus();
    checkOutput("adel_entry", {out_valid, out_adel, out_pc, out_inst},
                {2'b11, 32'h8000_0102, 32'h0});
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) applyStimulus();
    checkOutput("adel_popped", 65'(popCount), 65'd1);
    checkOutput("adel_halt_hs", 65'(addrLog.size()), 65'd0);
    checkOutput("adel_halt_req", 65'(inst_req), 65'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0200;
    applyStimulus();
    redirect_valid = 1'b0;
    waitAddrs(1, 5, "unhalt_wait");
    checkOutput("unhalt_addr", 65'(addrLog[0]), 65'h0_8000_0200);
    waitPops(2, 10, "unhalt_pop");

    $display("[TB] reset mid-transaction");
    lat = 3;
    out_ready = 1'b0;
    applyReset();
    waitAddrs(3, 30, "mid_wait");
    checkOutput("mid_head_pc", 65'(out_pc), 65'h0BFC0_0000);
    rst_p = 1'b1;
    applyStimulus();
    #1;
    checkOutput("mid_rst_valid", 65'(out_valid), 65'd0);
    checkOutput("mid_rst_req", 65'(inst_req), 65'd0);
    rst_p = 1'b0;
    addrLog.delete();
    popCount = 0;
    #1;
    checkOutput("mid_restart", {inst_req, inst_addr}, {1'b1, 32'hBFC0_0000});
    lat = 1;
    out_ready = 1'b1;
    waitPops(1, 10, "mid_pop");
    checkOutput("mid_first_pc", 65'(lastPopPc), 65'h0BFC0_0000);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
